// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: carries decoded control and operands from ID into EX.
// Latency: exactly one cycle; every output comes straight from a flop.
// Backpressure: stall holds all state, flush loads a bubble, and flush overrides stall.
//
// Ports:
//   clk, r                   clock, synchronous active-high reset
//   stall, flush             hazard-unit hold and redirect bubble
//   id_*                     ID-stage valid, control, datapath and index fields
//   ex_*                     registered EX-stage copies of the id_* fields
//   bubble_cnt               number of bubbles that entered EX, saturating
//
// Build option: define ID_EX_BUBBLE_CNT_EN to implement the bubble counter.
// When it is undefined, bubble_cnt is tied to zero and has no flops behind it.
module id_ex_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            r,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic            id_mem_read,
  input  logic            id_mem_2_reg,
  input  logic            id_mem_write,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_branch,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7_5,
  output logic            ex_valid,
  output logic            ex_mem_read,
  output logic            ex_mem_2_reg,
  output logic            ex_mem_write,
  output logic            ex_alu_src,
  output logic            ex_reg_write,
  output logic            ex_branch,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7_5,
  output logic [31:0]     bubble_cnt
);

  // Whole EX-stage payload kept as one packed record so reset and flush
  // can clear it in a single assignment.
  typedef struct packed {
    logic            valid;
    logic            mem_read;
    logic            mem_2_reg;
    logic            mem_write;
    logic            alu_src;
    logic            reg_write;
    logic            branch;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7_5;
  } ex_t;

  ex_t ex_q;
  ex_t ex_d;
  ex_t id_load;

  // Value captured on a normal load. Control is gated by id_valid so an empty
  // ID slot cannot write memory or registers, and writes to x0 are dropped here
  // so later stages never need to check rd.
  always_comb begin
    id_load           = '0;
    id_load.valid     = id_valid;
    id_load.mem_read  = id_valid & id_mem_read;
    id_load.mem_2_reg = id_valid & id_mem_2_reg;
    id_load.mem_write = id_valid & id_mem_write;
    id_load.alu_src   = id_valid & id_alu_src;
    id_load.reg_write = id_valid & id_reg_write & (id_rd != 5'd0);
    id_load.branch    = id_valid & id_branch;
    id_load.pc        = id_pc;
    id_load.rs1_data  = id_rs1_data;
    id_load.rs2_data  = id_rs2_data;
    id_load.imm       = id_imm;
    id_load.rs1       = id_rs1;
    id_load.rs2       = id_rs2;
    id_load.rd        = id_rd;
    id_load.funct3    = id_funct3;
    id_load.funct7_5  = id_funct7_5;
  end

  // Flush wins over stall: a redirect must squash EX even while ID is held.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (!stall) begin
      ex_d = id_load;
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_2_reg = ex_q.mem_2_reg;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_alu_src   = ex_q.alu_src;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_branch    = ex_q.branch;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1_data  = ex_q.rs1_data;
  assign ex_rs2_data  = ex_q.rs2_data;
  assign ex_imm       = ex_q.imm;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_funct3    = ex_q.funct3;
  assign ex_funct7_5  = ex_q.funct7_5;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic        bubble;
  logic [31:0] bubble_cnt_q;
  logic [31:0] bubble_cnt_d;

  // A bubble enters EX on a flush, or on a load of an empty ID slot.
  // A stalled edge moves nothing into EX, so it is never counted.
  assign bubble = flush | (~stall & ~id_valid);

  // Saturate rather than wrap so a long-running count never reads as small.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      bubble_cnt_q <= 32'd0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`else
  assign bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        r, stall, flush, id_valid;
  logic        id_mem_read, id_mem_2_reg, id_mem_write, id_alu_src, id_reg_write, id_branch;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic        id_funct7_5;
  logic        ex_valid, ex_mem_read, ex_mem_2_reg, ex_mem_write, ex_alu_src, ex_reg_write, ex_branch;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_funct7_5;
  logic [31:0] bubble_cnt;

  always #5 clk = ~clk;

  id_ex_reg #(.XLEN(32)) dut (
    .clk(clk), .r(r), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_mem_read(id_mem_read), .id_mem_2_reg(id_mem_2_reg), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_branch(id_branch),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_2_reg(ex_mem_2_reg),
    .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
    .ex_branch(ex_branch), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7_5(ex_funct7_5), .bubble_cnt(bubble_cnt)
  );

  // Observable EX state, as the reference model sees it.
  typedef struct packed {
    logic        valid, mem_read, mem_2_reg, mem_write, alu_src, reg_write, branch;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] cnt;
  } obs_t;

  obs_t mdl;
  obs_t dut_o;
  assign dut_o = {ex_valid, ex_mem_read, ex_mem_2_reg, ex_mem_write, ex_alu_src, ex_reg_write,
                  ex_branch, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                  ex_funct3, ex_funct7_5, bubble_cnt};

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Bubble count the DUT should report, given how many bubbles actually occurred.
  function automatic logic [31:0] exp_cnt(input logic [31:0] n);
`ifdef ID_EX_BUBBLE_CNT_EN
    return n;
`else
    return 32'd0 & n;
`endif
  endfunction

  // One pipeline slot seen from outside: reset empties it, a redirect turns
  // it into a bubble, a stall keeps it, otherwise it takes the ID instruction.
  function automatic void model_edge();
    logic bub;
    bub = 1'b0;
    if (r) begin
      mdl = '0;
    end else if (flush) begin
      mdl = '{default: '0, cnt: mdl.cnt};
      bub = 1'b1;
    end else if (!stall) begin
      mdl.valid     = id_valid;
      mdl.mem_read  = id_valid ? id_mem_read  : 1'b0;
      mdl.mem_2_reg = id_valid ? id_mem_2_reg : 1'b0;
      mdl.mem_write = id_valid ? id_mem_write : 1'b0;
      mdl.alu_src   = id_valid ? id_alu_src   : 1'b0;
      mdl.reg_write = (id_valid && id_rd != 0) ? id_reg_write : 1'b0;
      mdl.branch    = id_valid ? id_branch    : 1'b0;
      mdl.pc = id_pc; mdl.rs1_data = id_rs1_data; mdl.rs2_data = id_rs2_data; mdl.imm = id_imm;
      mdl.rs1 = id_rs1; mdl.rs2 = id_rs2; mdl.rd = id_rd;
      mdl.funct3 = id_funct3; mdl.funct7_5 = id_funct7_5;
      bub = !id_valid;
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    if (bub && (longint'(mdl.cnt) + 1 <= 64'hFFFF_FFFF)) mdl.cnt = mdl.cnt + 1;
`else
    if (bub) mdl.cnt = 32'd0;
`endif
  endfunction

  task automatic tick(input string name);
    model_edge();
    @(posedge clk);
    #1;
    chk(name, 256'(dut_o), 256'(mdl));
  endtask

  task automatic clear_inputs();
    {r, stall, flush, id_valid, id_mem_read, id_mem_2_reg, id_mem_write, id_alu_src,
     id_reg_write, id_branch, id_funct7_5} = '0;
    {id_pc, id_rs1_data, id_rs2_data, id_imm} = '0;
    {id_rs1, id_rs2, id_rd, id_funct3} = '0;
  endtask

  typedef struct {
    bit          r, stall, flush, valid, reg_write, mem_write;
    logic [31:0] pc;
    logic [4:0]  rd;
    bit          e_valid, e_reg_write, e_mem_write;
    logic [31:0] e_pc;
    logic [4:0]  e_rd;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[13];

  initial begin
    mdl = '0;
    clear_inputs();

    //           r  st fl v  rw mw pc        rd   ev erw emw e_pc      e_rd e_cnt
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 32'h000, 5'd0, 0, 0, 0, 32'h000, 5'd0, 0};
    tbl[1]  = '{0, 0, 0, 1, 1, 0, 32'h100, 5'd5, 1, 1, 0, 32'h100, 5'd5, 0};
    tbl[2]  = '{0, 0, 0, 1, 1, 0, 32'h104, 5'd0, 1, 0, 0, 32'h104, 5'd0, 0};
    tbl[3]  = '{0, 0, 0, 0, 1, 1, 32'h108, 5'd3, 0, 0, 0, 32'h108, 5'd3, 1};
    tbl[4]  = '{0, 0, 0, 1, 1, 0, 32'h200, 5'd7, 1, 1, 0, 32'h200, 5'd7, 1};
    tbl[5]  = '{0, 1, 0, 1, 1, 0, 32'h204, 5'd9, 1, 1, 0, 32'h200, 5'd7, 1};
    tbl[6]  = '{0, 1, 0, 1, 1, 0, 32'h204, 5'd9, 1, 1, 0, 32'h200, 5'd7, 1};
    tbl[7]  = '{0, 1, 0, 1, 1, 0, 32'h204, 5'd9, 1, 1, 0, 32'h200, 5'd7, 1};
    tbl[8]  = '{0, 1, 1, 1, 0, 1, 32'h204, 5'd9, 0, 0, 0, 32'h000, 5'd0, 2};
    tbl[9]  = '{0, 0, 1, 1, 1, 1, 32'h208, 5'd4, 0, 0, 0, 32'h000, 5'd0, 3};
    tbl[10] = '{0, 1, 0, 0, 1, 0, 32'h300, 5'd6, 0, 0, 0, 32'h000, 5'd0, 3};
    tbl[11] = '{1, 0, 1, 1, 1, 1, 32'h304, 5'd6, 0, 0, 0, 32'h000, 5'd0, 0};
    tbl[12] = '{0, 0, 0, 1, 0, 1, 32'h400, 5'd1, 1, 0, 1, 32'h400, 5'd1, 0};

    for (int i = 0; i < 13; i++) begin
      r = tbl[i].r; stall = tbl[i].stall; flush = tbl[i].flush; id_valid = tbl[i].valid;
      id_reg_write = tbl[i].reg_write; id_mem_write = tbl[i].mem_write;
      id_pc = tbl[i].pc; id_rd = tbl[i].rd;
      tick($sformatf("model_vec%0d", i));
      chk($sformatf("vec%0d", i),
          256'({ex_valid, ex_reg_write, ex_mem_write, ex_pc, ex_rd, bubble_cnt}),
          256'({tbl[i].e_valid, tbl[i].e_reg_write, tbl[i].e_mem_write, tbl[i].e_pc,
                tbl[i].e_rd, exp_cnt(tbl[i].e_cnt)}));
    end

    // Reset in the middle of a stall drops the held instruction.
    clear_inputs();
    r = 1'b1;
    tick("rms_reset0");
    r = 1'b0; flush = 1'b1;
    for (int i = 0; i < 7; i++) tick("rms_flush");
    flush = 1'b0; id_valid = 1'b1; id_pc = 32'h500; id_rd = 5'd2; id_reg_write = 1'b1;
    tick("rms_load");
    stall = 1'b1; id_pc = 32'h504;
    tick("rms_stall1");
    tick("rms_stall2");
    chk("rms_held", 256'({ex_valid, ex_pc, bubble_cnt}), 256'({1'b1, 32'h500, exp_cnt(32'd7)}));
    r = 1'b1;
    tick("rms_rst");
    chk("rms_zero", 256'(dut_o), 256'd0);
    r = 1'b0; stall = 1'b0; id_pc = 32'h600;
    tick("rms_after");
    chk("rms_reload", 256'({ex_valid, ex_pc, ex_rd, ex_reg_write}), 256'({1'b1, 32'h600, 5'd2, 1'b1}));

    // Counter saturation.
    clear_inputs();
`ifdef ID_EX_BUBBLE_CNT_EN
    force dut.bubble_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_cnt_q;
    mdl.cnt = 32'hFFFF_FFFE;
`endif
    flush = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick($sformatf("sat_model%0d", i));
      chk($sformatf("sat%0d", i), 256'(bubble_cnt), 256'(exp_cnt(32'hFFFF_FFFF)));
    end

    // Randomized traffic against the reference model.
    clear_inputs();
    for (int i = 0; i < 400; i++) begin
      r            = ($urandom_range(0, 39) == 0);
      flush        = ($urandom_range(0, 5) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_mem_read  = 1'($urandom);
      id_mem_2_reg = 1'($urandom);
      id_mem_write = 1'($urandom);
      id_alu_src   = 1'($urandom);
      id_reg_write = 1'($urandom);
      id_branch    = 1'($urandom);
      id_pc        = $urandom;
      id_rs1_data  = $urandom;
      id_rs2_data  = $urandom;
      id_imm       = $urandom;
      id_rs1       = 5'($urandom);
      id_rs2       = 5'($urandom);
      id_rd        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      id_funct3    = 3'($urandom);
      id_funct7_5  = 1'($urandom);
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
